// File: rtl/core_pkg.sv
// Shared core datapath types used by the vector load path.
package core_pkg;

    localparam int unsigned VrfDataWidth    = 64;
    localparam int unsigned VlenWidth       = 16;
    localparam int unsigned InsnIdWidth     = 4;
    localparam int unsigned PackerBeatWidth = 32;

    typedef logic [VrfDataWidth-1:0] vrf_data_t;
    typedef logic [VlenWidth-1:0]    vlen_t;
    typedef logic [InsnIdWidth-1:0]  insn_id_t;

endpackage

// File: rtl/vlu_load_packer_pkg.sv
// Local types and helpers for the VLU load-data packer.
package vlu_load_packer_pkg;

    typedef enum logic [1:0] {StIdle, StPack, StZero} packer_state_e;

    // Beat index needs at least one bit even when one beat fills a word.
    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/vlu_beat_masker.sv
// Zeroes every byte of a memory beat whose position is at or beyond the remaining byte count.
module vlu_beat_masker #(
    parameter int unsigned BeatWidth = 32,
    parameter int unsigned VlenW     = 16
) (
    input  logic [BeatWidth-1:0] i_beat,
    input  logic [VlenW-1:0]     i_bytes_left,
    output logic [BeatWidth-1:0] o_beat
);

    localparam int unsigned BeatBytes = BeatWidth / 8;

    always_comb begin
        o_beat = '0;
        for (int unsigned b = 0; b < BeatBytes; b++) begin
            if (i_bytes_left > VlenW'(b)) begin
                o_beat[b*8 +: 8] = i_beat[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/vlu_load_packer.sv
// Packs narrow memory beats little-endian into VRF words for the VLU load-operand port.
// Optional stall counter output enabled by defining VLU_LOAD_PACKER_PERF_EN.
module vlu_load_packer
    import core_pkg::*;
    import vlu_load_packer_pkg::*;
#(
    parameter int unsigned BeatWidth = PackerBeatWidth,
    parameter int unsigned DataWidth = $bits(vrf_data_t)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  vlen_t                 req_vlB_i,
    input  insn_id_t              req_insn_id_i,
    input  logic                  beat_valid_i,
    output logic                  beat_ready_o,
    input  logic [BeatWidth-1:0]  beat_data_i,
    output logic                  load_op_valid_o,
    input  logic                  load_op_ready_i,
    output logic [DataWidth-1:0]  load_op_o,
    output logic                  done_o,
    output insn_id_t              done_insn_id_o
`ifdef VLU_LOAD_PACKER_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned BeatBytes = BeatWidth / 8;
    localparam int unsigned Ratio     = DataWidth / BeatWidth;
    localparam int unsigned IdxW      = idx_width(Ratio);
    localparam int unsigned VlenW     = $bits(vlen_t);
    localparam int unsigned ShiftB    = $clog2(BeatBytes);

    packer_state_e        r_state;
    logic                 r_req_ready;
    insn_id_t             r_insn_id;
    vlen_t                r_beats_left;
    vlen_t                r_bytes_left;
    logic [IdxW-1:0]      r_beat_idx;
    logic [DataWidth-1:0] r_asm;
    logic [DataWidth-1:0] r_out;
    logic                 r_out_valid;

    logic [BeatWidth-1:0] w_beat_masked;
    logic [DataWidth-1:0] w_beat_placed;
    logic [DataWidth-1:0] w_word;
    logic [VlenW:0]       w_beats_ceil;
    logic                 w_beat_fire;
    logic                 w_word_done;
    logic                 w_out_fire;
    logic                 w_last_out;

    vlu_beat_masker #(
        .BeatWidth (BeatWidth),
        .VlenW     (VlenW)
    ) u_masker (
        .i_beat       (beat_data_i),
        .i_bytes_left (r_bytes_left),
        .o_beat       (w_beat_masked)
    );

    // One extra bit so the largest vlB cannot wrap before the shift.
    assign w_beats_ceil = ({1'b0, req_vlB_i} + (VlenW + 1)'(BeatBytes - 1)) >> ShiftB;

    assign w_out_fire    = r_out_valid && load_op_ready_i;
    assign beat_ready_o  = (r_state == StPack) && (r_beats_left != '0)
                           && (!r_out_valid || load_op_ready_i);
    assign w_beat_fire   = beat_valid_i && beat_ready_o;
    assign w_word_done   = w_beat_fire
                           && ((r_beat_idx == IdxW'(Ratio - 1)) || (r_beats_left == VlenW'(1)));
    assign w_beat_placed = DataWidth'(w_beat_masked) << (r_beat_idx * BeatWidth);
    assign w_word        = r_asm | w_beat_placed;

    // Once all beats are in, the output register necessarily holds the final word.
    assign w_last_out     = (r_state == StPack) && (r_beats_left == '0) && w_out_fire;
    assign done_o         = (r_state == StZero) || w_last_out;
    assign done_insn_id_o = done_o ? r_insn_id : '0;

    assign req_ready_o     = r_req_ready;
    assign load_op_valid_o = r_out_valid;
    assign load_op_o       = r_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_req_ready  <= 1'b0;
            r_insn_id    <= '0;
            r_beats_left <= '0;
            r_bytes_left <= '0;
            r_beat_idx   <= '0;
            r_asm        <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid_i && r_req_ready) begin
                        r_insn_id    <= req_insn_id_i;
                        r_beats_left <= w_beats_ceil[VlenW-1:0];
                        r_bytes_left <= req_vlB_i;
                        r_beat_idx   <= '0;
                        r_asm        <= '0;
                        r_req_ready  <= 1'b0;
                        r_state      <= (req_vlB_i != '0) ? StPack : StZero;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                StZero: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
                StPack: begin
                    if (w_beat_fire) begin
                        r_beats_left <= r_beats_left - VlenW'(1);
                        r_bytes_left <= (r_bytes_left > VlenW'(BeatBytes))
                                        ? r_bytes_left - VlenW'(BeatBytes) : '0;
                        if (w_word_done) begin
                            r_asm      <= '0;
                            r_beat_idx <= '0;
                        end else begin
                            r_asm      <= w_word;
                            r_beat_idx <= r_beat_idx + 1'b1;
                        end
                    end
                    if (w_word_done) begin
                        r_out       <= w_word;
                        r_out_valid <= 1'b1;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_last_out) begin
                        r_state     <= StIdle;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef VLU_LOAD_PACKER_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StPack) && r_out_valid && !load_op_ready_i
                     && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vlu_load_packer.sv
// Self-checking bench for vlu_load_packer with a byte-stream reference model.
module tb_vlu_load_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [15:0] req_vlB_i;
    logic [3:0]  req_insn_id_i;
    logic        beat_valid_i;
    logic        beat_ready_o;
    logic [31:0] beat_data_i;
    logic        load_op_valid_o;
    logic        load_op_ready_i;
    logic [63:0] load_op_o;
    logic        done_o;
    logic [3:0]  done_insn_id_o;
`ifdef VLU_LOAD_PACKER_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    vlu_load_packer u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_vlB_i       (req_vlB_i),
        .req_insn_id_i   (req_insn_id_i),
        .beat_valid_i    (beat_valid_i),
        .beat_ready_o    (beat_ready_o),
        .beat_data_i     (beat_data_i),
        .load_op_valid_o (load_op_valid_o),
        .load_op_ready_i (load_op_ready_i),
        .load_op_o       (load_op_o),
        .done_o          (done_o),
        .done_insn_id_o  (done_insn_id_o)
`ifdef VLU_LOAD_PACKER_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] tb_beats[$];
    logic [63:0] got_words[$];
    int          n_beats, n_done, done_cyc, hs_cyc, br_cycles, ov_cycles;
    logic [3:0]  done_id;
    bit          done_with_hs, stall_seen;

    // Reference: stream byte j is byte (j%4) of beat j/4 when j < vlB, else 0.
    function automatic logic [63:0] exp_word(input int vlb, input int k);
        logic [63:0] w;
        logic [31:0] b;
        w = '0;
        for (int m = 0; m < 8; m++) begin
            int j;
            j = 8 * k + m;
            if (j < vlb) begin
                b = tb_beats[j / 4];
                w[8*m +: 8] = 8'(b >> (8 * (j % 4)));
            end
        end
        return w;
    endfunction

    task automatic idle_inputs();
        req_valid_i     = 1'b0;
        req_vlB_i       = '0;
        req_insn_id_i   = '0;
        beat_valid_i    = 1'b0;
        beat_data_i     = '0;
        load_op_ready_i = 1'b1;
    endtask

    // Drives one instruction cycle by cycle; records what happened for the calling test.
    task automatic run_insn(input int vlb, input logic [3:0] id, input int beat_pct,
                            input int rdy_pct, input int offer, input int stall_len,
                            input int stop_beats);
        int cyc, bi, tail, first_cyc;
        bit req_pending;
        cyc = 0; bi = 0; tail = -1; first_cyc = -1; req_pending = 1'b1;
        got_words.delete();
        n_done = 0; done_cyc = -1; hs_cyc = -1; br_cycles = 0; ov_cycles = 0;
        done_id = '0; done_with_hs = 1'b0; stall_seen = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk_i);
            req_valid_i     = req_pending;
            req_vlB_i       = 16'(vlb);
            req_insn_id_i   = id;
            beat_valid_i    = (hs_cyc >= 0) && (bi < offer) && ($urandom_range(99) < beat_pct);
            beat_data_i     = (bi < tb_beats.size()) ? tb_beats[bi] : $urandom;
            load_op_ready_i = ($urandom_range(99) < rdy_pct)
                              && !(first_cyc >= 0 && cyc > first_cyc && cyc <= first_cyc + stall_len);
            #1;
            if (req_valid_i && req_ready_o) begin
                hs_cyc = cyc;
                req_pending = 1'b0;
            end
            if (beat_ready_o) br_cycles++;
            if (load_op_valid_o) ov_cycles++;
            if (first_cyc >= 0 && cyc > first_cyc && cyc <= first_cyc + stall_len
                && !beat_ready_o && bi < offer) stall_seen = 1'b1;
            if (beat_valid_i && beat_ready_o) bi++;
            if (load_op_valid_o && load_op_ready_i) begin
                got_words.push_back(load_op_o);
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (done_o) begin
                n_done++;
                done_id = done_insn_id_o;
                done_cyc = cyc;
                done_with_hs = load_op_valid_o && load_op_ready_i;
                if (tail < 0) tail = 4;
            end
            cyc++;
            if (stop_beats > 0 && bi == stop_beats) begin
                @(posedge clk_i);
                break;
            end
            if (tail > 0) tail--;
            else if (tail == 0) break;
        end
        n_beats = bi;
        if (stop_beats == 0) begin
            @(negedge clk_i);
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({req_ready_o, beat_ready_o, load_op_valid_o, done_o} !== 4'b0
            || load_op_o !== 64'h0 || done_insn_id_o !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy/brdy/v/done=%b op=%h id=%h want all 0",
                     {req_ready_o, beat_ready_o, load_op_valid_o, done_o}, load_op_o, done_insn_id_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_full_words();
        tb_beats = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_insn(16, 4'd3, 100, 100, 4, 0, 0);
        n_cmp++;
        if (got_words.size() !== 2) begin
            n_bad++; $display("FAIL full_count: got %0d words want 2", got_words.size());
        end
        n_cmp++;
        if (got_words[0] !== 64'h0000000B_0000000A) begin
            n_bad++; $display("FAIL full_w0: got %h want 0000000b0000000a", got_words[0]);
        end
        n_cmp++;
        if (got_words[1] !== 64'h0000000D_0000000C) begin
            n_bad++; $display("FAIL full_w1: got %h want 0000000d0000000c", got_words[1]);
        end
        n_cmp++;
        if (n_beats !== 4) begin
            n_bad++; $display("FAIL full_beats: got %0d want 4", n_beats);
        end
        n_cmp++;
        if (n_done !== 1 || !done_with_hs || done_id !== 4'd3) begin
            n_bad++;
            $display("FAIL full_done: got n=%0d hs=%b id=%0d want n=1 hs=1 id=3",
                     n_done, done_with_hs, done_id);
        end
    endtask

    task automatic test_partial();
        tb_beats = '{32'h11223344, 32'hAABBCCDD};
        run_insn(6, 4'd9, 100, 100, 2, 0, 0);
        n_cmp++;
        if (got_words.size() !== 1 || got_words[0] !== 64'h0000CCDD_11223344) begin
            n_bad++;
            $display("FAIL partial_word: got n=%0d w=%h want n=1 w=0000ccdd11223344",
                     got_words.size(), got_words[0]);
        end
        n_cmp++;
        if (n_done !== 1 || done_id !== 4'd9) begin
            n_bad++; $display("FAIL partial_done: got n=%0d id=%0d want 1/9", n_done, done_id);
        end
    endtask

    task automatic test_overoffer();
        tb_beats = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_insn(12, 4'd1, 100, 100, 4, 0, 0);
        n_cmp++;
        if (got_words.size() !== 2 || got_words[0] !== 64'h00000002_00000001
            || got_words[1] !== 64'h00000000_00000003) begin
            n_bad++;
            $display("FAIL over_words: got n=%0d %h %h want 2 0000000200000001 0000000000000003",
                     got_words.size(), got_words[0], got_words[1]);
        end
        n_cmp++;
        if (n_beats !== 3) begin
            n_bad++; $display("FAIL over_beats: got %0d want 3", n_beats);
        end
    endtask

    task automatic test_backpressure();
        tb_beats.delete();
        for (int i = 0; i < 8; i++) tb_beats.push_back($urandom);
        run_insn(32, 4'd6, 100, 100, 8, 5, 0);
        n_cmp++;
        if (got_words.size() !== 4 || n_beats !== 8) begin
            n_bad++;
            $display("FAIL bp_counts: got words=%0d beats=%0d want 4/8", got_words.size(), n_beats);
        end
        for (int k = 0; k < got_words.size(); k++) begin
            n_cmp++;
            if (got_words[k] !== exp_word(32, k)) begin
                n_bad++; $display("FAIL bp_word%0d: got %h want %h", k, got_words[k], exp_word(32, k));
            end
        end
        n_cmp++;
        if (!stall_seen || n_done !== 1) begin
            n_bad++; $display("FAIL bp_stall: got stall=%b done=%0d want 1/1", stall_seen, n_done);
        end
    endtask

    task automatic test_zero();
        tb_beats = '{32'hDEAD, 32'hBEEF};
        run_insn(0, 4'd5, 100, 100, 2, 0, 0);
        n_cmp++;
        if (br_cycles !== 0 || ov_cycles !== 0 || n_beats !== 0) begin
            n_bad++;
            $display("FAIL zero_quiet: got brdy=%0d valid=%0d beats=%0d want 0/0/0",
                     br_cycles, ov_cycles, n_beats);
        end
        n_cmp++;
        if (n_done !== 1 || done_id !== 4'd5 || done_cyc !== hs_cyc + 1) begin
            n_bad++;
            $display("FAIL zero_done: got n=%0d id=%0d cyc=%0d want 1/5/%0d",
                     n_done, done_id, done_cyc, hs_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        tb_beats.delete();
        for (int i = 0; i < 4; i++) tb_beats.push_back($urandom);
        run_insn(16, 4'd7, 100, 100, 4, 0, 2);
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        n_cmp++;
        if ({req_ready_o, beat_ready_o, load_op_valid_o, done_o} !== 4'b0
            || load_op_o !== 64'h0 || done_insn_id_o !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got rdy/brdy/v/done=%b op=%h id=%h want all 0",
                     {req_ready_o, beat_ready_o, load_op_valid_o, done_o}, load_op_o, done_insn_id_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL midrst_idle: got %b want 1", req_ready_o);
        end
        tb_beats = '{$urandom, $urandom};
        run_insn(8, 4'd2, 100, 100, 2, 0, 0);
        n_cmp++;
        if (got_words.size() !== 1 || got_words[0] !== exp_word(8, 0) || n_done !== 1
            || done_id !== 4'd2) begin
            n_bad++;
            $display("FAIL midrst_fresh: got n=%0d w=%h done=%0d id=%0d want 1 %h 1 2",
                     got_words.size(), got_words[0], n_done, done_id, exp_word(8, 0));
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int vlb, nb, nw;
            logic [3:0] id;
            vlb = $urandom_range(40);
            id  = 4'($urandom);
            nb  = (vlb + 3) / 4;
            nw  = (vlb + 7) / 8;
            tb_beats.delete();
            for (int i = 0; i < nb + 2; i++) tb_beats.push_back($urandom);
            run_insn(vlb, id, $urandom_range(100, 30), $urandom_range(100, 30), nb + 2, 0, 0);
            n_cmp++;
            if (got_words.size() !== nw || n_beats !== nb || n_done !== 1 || done_id !== id
                || (vlb > 0 && !done_with_hs)) begin
                n_bad++;
                $display("FAIL rand%0d_ctrl: vlB=%0d got w=%0d b=%0d d=%0d id=%0d hs=%b want %0d/%0d/1/%0d",
                         t, vlb, got_words.size(), n_beats, n_done, done_id, done_with_hs, nw, nb, id);
            end
            for (int k = 0; k < got_words.size(); k++) begin
                n_cmp++;
                if (got_words[k] !== exp_word(vlb, k)) begin
                    n_bad++;
                    $display("FAIL rand%0d_word%0d: got %h want %h", t, k, got_words[k], exp_word(vlb, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_overoffer();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vlu_load_packer.md
Name: vlu_load_packer

Overview:
- Upstream feeder of the vector load unit.
- Collects narrow load-data beats returned by the scalar core's memory port and packs them, little-endian, into full vrf_data_t words.
- Drives the VLU's load-operand handshake, one word per transfer.
- Per instruction it knows the byte count (vlB): it consumes exactly ceil(vlB/BeatBytes) beats, zero-pads past vlB, and reports completion.

Parameters:
BeatWidth, 32, memory beat width in bits; DataWidth must be an integer power-of-two multiple of it.
DataWidth, $bits(vrf_data_t), output word width in bits.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  new load instruction valid
req_ready_o  out  1  packer can accept an instruction
req_vlB_i  in  $bits(vlen_t)  instruction length in bytes
req_insn_id_i  in  $bits(insn_id_t)  instruction id
beat_valid_i  in  1  memory beat valid
beat_ready_o  out  1  beat accepted when high with valid
beat_data_i  in  BeatWidth  memory beat, byte 0 in bits [7:0]
load_op_valid_o  out  1  packed word valid (to VLU load_op_valid_i)
load_op_ready_i  in  1  VLU accepts word
load_op_o  out  DataWidth  packed word
done_o  out  1  one-cycle pulse, instruction fully delivered
done_insn_id_o  out  $bits(insn_id_t)  id of finished instruction

Behaviour:
- Reset values: req_ready_o=0 during reset and 1 after (state IDLE); beat_ready_o=0; load_op_valid_o=0; load_op_o=0; done_o=0; done_insn_id_o=0. All counters, assembly and output registers are cleared.
- Reset mid-instruction aborts it: no done_o, partial word discarded.
- Derived constants:
  - BeatBytes = BeatWidth/8.
  - Ratio = DataWidth/BeatWidth.
  - beat_idx width = max(1, log2(Ratio)).
- States and transitions:
  - IDLE: req_ready_o=1. On req handshake, latch insn_id and set beats_left=ceil(vlB/BeatBytes) and bytes_left=vlB. Go to PACK if vlB>0, else ZERO.
  - ZERO: done_o=1 for one cycle; go to IDLE. No beats consumed, no words produced.
  - PACK: beat_ready_o = (beats_left!=0) && (!out_valid_q || load_op_ready_i).
    - Each accepted beat is written into assembly slot beat_idx; beat_idx++; beats_left--.
    - Bytes of that beat at positions >= bytes_left are forced to 0; bytes_left saturates at 0.
    - A word is complete when beat_idx==Ratio-1 or beats_left==1. The completing beat plus the assembly slots (unfilled slots = 0) load the output register at the next edge. load_op_valid_o is therefore asserted 1 cycle after the completing beat. The assembly register clears and beat_idx returns to 0.
    - The output register holds its value while valid && !ready.
    - The last word's output handshake (beats_left==0 and no pending assembly) asserts done_o combinationally in that same cycle, with done_insn_id_o = latched id. Go to IDLE the next cycle.
- Throughput: one beat per cycle sustained under no backpressure.
- Simultaneous output handshake and new word completion in the same cycle: the output register is replaced with no bubble.
- req_ready_o=0 outside IDLE. A request presented in PACK or ZERO waits.
- beat_valid_i outside PACK is ignored (ready=0).
- Width rules: all counters are $bits(vlen_t). Beat-count ceiling uses (vlB+BeatBytes-1)>>log2(BeatBytes) computed at vlen_t+1 bits, so the maximum vlB has no overflow.

Optional Feature:
- Macro: VLU_LOAD_PACKER_PERF_EN.
- Defined: adds output port stall_cnt_o (32 bits), reset to 0. It increments every cycle in PACK with load_op_valid_o && !load_op_ready_i, saturates at 2^32-1, and is never cleared except by reset.
- Undefined: port and counter are absent; functional behaviour is otherwise identical.

Decomposition:
- core_pkg: vrf_data_t, vlen_t, insn_id_t, and a new PackerBeatWidth constant.
- Local state enum {IDLE, PACK, ZERO}.
- One natural sub-module: vlu_beat_masker, the combinational zeroing of bytes >= bytes_left within a beat. Everything else stays in the top.

Test Plan (BeatWidth=32, DataWidth=64):
1. vlB=16, beats 0xA,0xB,0xC,0xD, ready tied 1 -> words 0x0000000B_0000000A then 0x0000000D_0000000C. done_o coincides with the 2nd output handshake. Exactly 4 beats consumed.
2. vlB=6, beats 0x11223344, 0xAABBCCDD -> single word 0x0000CCDD_11223344, then done_o.
3. vlB=12, beats 1,2,3 -> words 0x00000002_00000001 and 0x00000000_00000003. A 4th offered beat is not accepted.
4. vlB=32, load_op_ready_i low 5 cycles after the first word -> beat_ready_o drops once the output is full and the assembly completes. All 8 beats are delivered in order with no loss or duplication.
5. vlB=0 with insn_id=5 -> no beat_ready_o, no load_op_valid_o. done_o=1 with id 5 exactly one cycle after the request handshake.
6. rst_ni asserted after 2 of 4 beats in PACK -> all outputs 0 immediately, IDLE after release. A fresh vlB=8 instruction then completes normally.
